// File: rtl/vec_cordic_pkg.sv
// Shared types and helpers for the iterative vectoring CORDIC sequencer.
package vec_cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam logic MICRO_ROT_CW  = 1'b0;
  localparam logic MICRO_ROT_CCW = 1'b1;

  function automatic int cnt_width(input int num_iter);
    return (num_iter < 2) ? 1 : $clog2(num_iter);
  endfunction

endpackage

// File: rtl/vec_cordic_iter_dp.sv
// Combinational shift-add micro-rotation for one vectoring CORDIC iteration.
module vec_cordic_iter_dp
  import vec_cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22,
  parameter int CNT_W        = 4
) (
  input  logic signed [CORDIC_WIDTH-1:0] x,
  input  logic signed [CORDIC_WIDTH-1:0] y,
  input  logic        [CNT_W-1:0]        iter,
  output logic signed [CORDIC_WIDTH-1:0] x_nxt,
  output logic signed [CORDIC_WIDTH-1:0] y_nxt,
  output logic                           dir
);

  logic signed [CORDIC_WIDTH-1:0] x_sh;
  logic signed [CORDIC_WIDTH-1:0] y_sh;

  always_comb begin
    x_sh = x >>> iter;
    y_sh = y >>> iter;
    // Iteration 0 is the fixed clockwise 45 deg step; a zero shift makes it the plain CW form.
    if (iter == '0) begin
      dir = MICRO_ROT_CW;
    end else begin
      dir = y[CORDIC_WIDTH-1] ? MICRO_ROT_CCW : MICRO_ROT_CW;
    end
    if (dir == MICRO_ROT_CCW) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
    end
  end

endmodule

// File: rtl/vec_cordic_iter_ctrl.sv
// Iterative vectoring-mode CORDIC sequencer: one micro-rotation per clock on a
// shared datapath, streaming direction bits and presenting the final vector.
module vec_cordic_iter_ctrl
  import vec_cordic_pkg::*;
#(
  parameter int CORDIC_WIDTH = 22,
  parameter int NUM_ITER     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [CORDIC_WIDTH-1:0] x_in,
  input  logic signed [CORDIC_WIDTH-1:0] y_in,
  input  logic                           abort,
  output logic                           micro_rot_o,
  output logic                           micro_rot_valid,
  output logic                           micro_rot_start,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [CORDIC_WIDTH-1:0] x_out,
  output logic signed [CORDIC_WIDTH-1:0] y_out,
  output logic        [NUM_ITER-1:0]     micro_rot_vec
);

  localparam int CNT_W = cnt_width(NUM_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER - 1);

  state_t                         state;
  logic signed [CORDIC_WIDTH-1:0] x_r;
  logic signed [CORDIC_WIDTH-1:0] y_r;
  logic        [CNT_W-1:0]        iter;
  logic signed [CORDIC_WIDTH-1:0] x_nxt;
  logic signed [CORDIC_WIDTH-1:0] y_nxt;
  logic                           dir_nxt;

  vec_cordic_iter_dp #(
    .CORDIC_WIDTH(CORDIC_WIDTH),
    .CNT_W       (CNT_W)
  ) u_dp (
    .x    (x_r),
    .y    (y_r),
    .iter (iter),
    .x_nxt(x_nxt),
    .y_nxt(y_nxt),
    .dir  (dir_nxt)
  );

  // abort only masks the DONE handoff; in IDLE it has no effect.
  always_comb begin
    in_ready = (state == IDLE) || ((state == DONE) && out_ready && !abort);
  end

  assign x_out = x_r;
  assign y_out = y_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      x_r             <= '0;
      y_r             <= '0;
      iter            <= '0;
      micro_rot_vec   <= '0;
      micro_rot_o     <= 1'b0;
      micro_rot_valid <= 1'b0;
      micro_rot_start <= 1'b0;
      out_valid       <= 1'b0;
    end else begin
      micro_rot_valid <= 1'b0;
      micro_rot_start <= 1'b0;
      // Load path serves both IDLE and the bubble-free DONE handoff.
      if (in_valid && in_ready) begin
        x_r           <= x_in;
        y_r           <= y_in;
        iter          <= '0;
        micro_rot_vec <= '0;
        out_valid     <= 1'b0;
        state         <= ITER;
      end else begin
        unique case (state)
          ITER: begin
            if (abort) begin
              state <= IDLE;
            end else begin
              x_r                 <= x_nxt;
              y_r                 <= y_nxt;
              micro_rot_o         <= dir_nxt;
              micro_rot_valid     <= 1'b1;
              micro_rot_start     <= (iter == '0);
              micro_rot_vec[iter] <= dir_nxt;
              if (iter == LAST_ITER) begin
                out_valid <= 1'b1;
                state     <= DONE;
              end else begin
                iter <= iter + 1'b1;
              end
            end
          end
          DONE: begin
            if (abort || out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_cordic_iter_ctrl.sv
// Self-checking bench for vec_cordic_iter_ctrl against an arithmetic CORDIC reference.
module tb_vec_cordic_iter_ctrl;

  localparam int W = 22;
  localparam int N = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic                abort;
  logic                micro_rot_o;
  logic                micro_rot_valid;
  logic                micro_rot_start;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic [N-1:0]        micro_rot_vec;

  int vectors     = 0;
  int miscompares = 0;

  longint       mx[0:N];
  longint       my[0:N];
  logic [N-1:0] mbits;
  longint       obs_x[0:N-1];
  longint       obs_y[0:N-1];

  vec_cordic_iter_ctrl #(
    .CORDIC_WIDTH(W),
    .NUM_ITER    (N)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .x_in           (x_in),
    .y_in           (y_in),
    .abort          (abort),
    .micro_rot_o    (micro_rot_o),
    .micro_rot_valid(micro_rot_valid),
    .micro_rot_start(micro_rot_start),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .x_out          (x_out),
    .y_out          (y_out),
    .micro_rot_vec  (micro_rot_vec)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v);
    longint m;
    m = v & ((longint'(1) << W) - 1);
    if (m >= (longint'(1) << (W - 1))) m = m - (longint'(1) << W);
    return m;
  endfunction

  function automatic longint floor_pow2(input longint v, input int k);
    longint d;
    d = longint'(1) << k;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  // Reference: rotate toward the x axis, scaling by 2^-k, W-bit wraparound.
  task automatic model(input longint xi, input longint yi);
    bit     ccw;
    longint s;
    mx[0] = wrapw(xi);
    my[0] = wrapw(yi);
    for (int k = 0; k < N; k++) begin
      ccw = (k != 0) && (my[k] < 0);
      s = ccw ? -1 : 1;
      mx[k+1] = wrapw(mx[k] + s * floor_pow2(my[k], k));
      my[k+1] = wrapw(my[k] - s * floor_pow2(mx[k], k));
      mbits[k] = ccw;
    end
  endtask

  task automatic start_vec(input longint xi, input longint yi);
    int g;
    model(xi, yi);
    in_valid = 1'b1;
    x_in = W'(xi);
    y_in = W'(yi);
    g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_wait", longint'(in_ready), 1);
  endtask

  task automatic expect_iters(input bit keep_valid, input longint nx, input longint ny);
    @(negedge clk);
    chk("load_no_strobe", longint'(micro_rot_valid), 0);
    chk("load_no_outv", longint'(out_valid), 0);
    chk("iter_not_ready", longint'(in_ready), 0);
    in_valid = keep_valid;
    x_in = W'(nx);
    y_in = W'(ny);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      obs_x[k] = longint'(x_out);
      obs_y[k] = longint'(y_out);
      chk($sformatf("strobe_i%0d", k), longint'(micro_rot_valid), 1);
      chk($sformatf("start_i%0d", k), longint'(micro_rot_start), (k == 0) ? 1 : 0);
      chk($sformatf("bit_i%0d", k), longint'(micro_rot_o), longint'(mbits[k]));
      chk($sformatf("vecbit_i%0d", k), longint'(micro_rot_vec[k]), longint'(mbits[k]));
      chk($sformatf("x_i%0d", k), longint'(x_out), mx[k+1]);
      chk($sformatf("y_i%0d", k), longint'(y_out), my[k+1]);
      chk($sformatf("outv_i%0d", k), longint'(out_valid), (k == N - 1) ? 1 : 0);
    end
    chk("final_vec", longint'(micro_rot_vec), longint'(mbits));
  endtask

  task automatic finish_vec(input int hold);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      x_in = W'($urandom_range(0, 4095));
      y_in = W'($urandom_range(0, 4095));
      @(negedge clk);
      chk("hold_outv", longint'(out_valid), 1);
      chk("hold_x", longint'(x_out), mx[N]);
      chk("hold_y", longint'(y_out), my[N]);
      chk("hold_vec", longint'(micro_rot_vec), longint'(mbits));
      chk("hold_not_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    if (hold > 0) begin
      out_ready = 1'b1;
      #1;
      chk("release_ready", longint'(in_ready), 1);
    end
    @(negedge clk);
    chk("drain_outv", longint'(out_valid), 0);
    chk("drain_ready", longint'(in_ready), 1);
    chk("drain_strobe", longint'(micro_rot_valid), 0);
  endtask

  initial begin
    longint rx;
    longint ry;
    int     hold;
    bit     seen;

    reset = 1'b1;
    in_valid = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    x_in = '0;
    y_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_outv", longint'(out_valid), 0);
    chk("rst_strobe", longint'(micro_rot_valid), 0);
    chk("rst_x", longint'(x_out), 0);
    chk("rst_vec", longint'(micro_rot_vec), 0);
    chk("rst_ready", longint'(in_ready), 1);

    // Reference vector (1000,0)
    out_ready = 1'b1;
    start_vec(1000, 0);
    expect_iters(1'b0, 0, 0);
    chk("ref_vec3_0", longint'(micro_rot_vec[3:0]), 4'b1110);
    chk("ref_x_i3", obs_x[3], 1641);
    chk("ref_y_i3", obs_y[3], 78);
    chk("ref_mag", (x_out >= 1631 && x_out <= 1663) ? 1 : 0, 1);
    chk("ref_resid", (y_out >= -4 && y_out <= 4) ? 1 : 0, 1);
    finish_vec(0);

    // Negative x with backpressure
    out_ready = 1'b0;
    start_vec(-2000, 1);
    expect_iters(1'b0, 0, 0);
    finish_vec(10);

    // Back-to-back: second vector held on in_valid throughout the first
    out_ready = 1'b1;
    start_vec(1000, 0);
    expect_iters(1'b1, 0, -500);
    chk("b2b_ready", longint'(in_ready), 1);
    model(0, -500);
    expect_iters(1'b0, 0, 0);
    chk("b2b_vec1", longint'(micro_rot_vec[1]), 1);
    finish_vec(0);

    // Abort at iteration 5
    start_vec(1234, -567);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    chk("abort_pre_strobe", longint'(micro_rot_valid), 1);
    abort = 1'b1;
    #1;
    chk("abort_not_ready", longint'(in_ready), 0);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_strobe", longint'(micro_rot_valid), 0);
    chk("abort_idle", longint'(in_ready), 1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | micro_rot_valid | out_valid;
    end
    chk("abort_quiet", longint'(seen), 0);
    start_vec(300, 300);
    expect_iters(1'b0, 0, 0);
    chk("post_abort_resid", (y_out >= -4 && y_out <= 4) ? 1 : 0, 1);
    finish_vec(0);

    // Abort in DONE beats out_ready and in_valid
    out_ready = 1'b0;
    start_vec(5000, -3000);
    expect_iters(1'b0, 0, 0);
    abort = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    x_in = W'(77);
    y_in = W'(88);
    #1;
    chk("done_abort_ready", longint'(in_ready), 0);
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    chk("done_abort_outv", longint'(out_valid), 0);
    chk("done_abort_idle", longint'(in_ready), 1);
    @(negedge clk);
    chk("done_abort_nocap", longint'(micro_rot_valid), 0);

    // Two's-complement wrap, no saturation
    start_vec(longint'(1) << (W - 2), longint'(1) << (W - 2));
    expect_iters(1'b0, 0, 0);
    chk("wrap_x_i0", obs_x[0], -(longint'(1) << (W - 1)));
    chk("wrap_y_i0", obs_y[0], 0);
    finish_vec(0);

    // Randomized vectors and backpressure
    for (int r = 0; r < 25; r++) begin
      rx = longint'($urandom_range(0, 1 << (W - 2))) - (longint'(1) << (W - 3));
      ry = longint'($urandom_range(0, 1 << (W - 2))) - (longint'(1) << (W - 3));
      hold = int'($urandom_range(0, 2));
      out_ready = (hold == 0);
      start_vec(rx, ry);
      expect_iters(1'b0, 0, 0);
      finish_vec(hold);
    end

    // Reset held 3 cycles mid-ITER
    out_ready = 1'b1;
    start_vec(777, 111);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_strobe", longint'(micro_rot_valid), 0);
    chk("mid_rst_start", longint'(micro_rot_start), 0);
    chk("mid_rst_bit", longint'(micro_rot_o), 0);
    chk("mid_rst_outv", longint'(out_valid), 0);
    chk("mid_rst_x", longint'(x_out), 0);
    chk("mid_rst_y", longint'(y_out), 0);
    chk("mid_rst_vec", longint'(micro_rot_vec), 0);
    reset = 1'b0;
    chk("mid_rst_ready", longint'(in_ready), 1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      seen = seen | micro_rot_valid | out_valid;
    end
    chk("mid_rst_quiet", longint'(seen), 0);
    start_vec(-1500, -900);
    expect_iters(1'b0, 0, 0);
    finish_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vec_cordic_iter_ctrl.md
Name: vec_cordic_iter_ctrl

Overview:
- Iterative vectoring-mode CORDIC sequencer. It accepts one (x,y) vector and drives a single shared shift-add datapath for NUM_ITER micro-rotations, one per clock.
- Each cycle it streams the micro-rotation direction bit to downstream rotation-mode blocks. At the end it presents the final (x,y) pair plus the packed direction vector.
- It is the area-reduced alternative to the fully unrolled vectoring pipeline and sits between the ICA angle-estimation front end and the rotation engines.

Parameters:
- CORDIC_WIDTH, 22, signed width of x/y datapath and ports.
- NUM_ITER, 16, total micro-rotations including the fixed 45 deg iteration 0; legal range 2..CORDIC_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  input vector valid
- in_ready  output  1  block can accept a vector this cycle
- x_in  input  CORDIC_WIDTH  signed x component
- y_in  input  CORDIC_WIDTH  signed y component
- abort  input  1  synchronous cancel of current operation
- micro_rot_o  output  1  direction bit of the iteration just completed (0 = clockwise, 1 = counter-clockwise)
- micro_rot_valid  output  1  strobe qualifying micro_rot_o
- micro_rot_start  output  1  high with the iteration-0 strobe only
- out_valid  output  1  final result valid; held until accepted
- out_ready  input  1  downstream accepts result
- x_out  output  CORDIC_WIDTH  final x (magnitude times CORDIC gain)
- y_out  output  CORDIC_WIDTH  final residual y
- micro_rot_vec  output  NUM_ITER  packed direction bits; bit i = iteration i

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - FSM goes to IDLE.
  - x/y registers, micro_rot_vec, iteration counter, micro_rot_o, micro_rot_valid, micro_rot_start and out_valid are all cleared to 0.
  - Reset mid-operation discards all state; no out_valid is produced.
- FSM states: IDLE, ITER, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load x_in/y_in, clear counter and vector, go to ITER.
- ITER, one iteration per cycle with counter i = 0..NUM_ITER-1:
  - i=0 (fixed clockwise 45 deg): x <= x+y, y <= y-x, bit=0, micro_rot_start=1 for that strobe.
  - i>=1, y>=0 (clockwise): x <= x+(y>>>i), y <= y-(x>>>i), bit=0.
  - i>=1, y<0 (counter-clockwise): x <= x-(y>>>i), y <= y+(x>>>i), bit=1.
  - Direction is decided from y before the update.
  - Shifts are arithmetic.
  - Add/sub is CORDIC_WIDTH-bit two's-complement wrap with no saturation; the caller guarantees about 2 bits of headroom.
  - Registered outputs: micro_rot_o=bit, micro_rot_valid=1 and micro_rot_vec[i]=bit appear the cycle after iteration i executes.
  - After i=NUM_ITER-1 the FSM goes to DONE.
- Latency: input accepted at edge T; micro_rot_valid is high T+1..T+NUM_ITER; out_valid is first high at T+NUM_ITER.
- DONE:
  - out_valid=1; x_out, y_out and micro_rot_vec are stable.
  - Outputs hold while out_ready=0.
  - On out_ready: back-to-back, in_ready=out_ready. If in_valid is also high, the new vector loads and the FSM enters ITER with no bubble; otherwise it goes to IDLE.
- in_ready is combinational: (IDLE) or (DONE and out_ready). It is 0 in ITER.
- micro_rot_valid and micro_rot_start are 0 outside iteration strobes.
- abort:
  - In ITER or DONE: go to IDLE next cycle, out_valid=0, strobes=0, in_ready=0 that cycle.
  - In IDLE: no effect.
  - abort wins over in_valid and out_ready in the same cycle.
- in_valid while not ready is ignored; inputs are not captured.

Decomposition:
- Package vec_cordic_pkg holds:
  - state_t enum {IDLE, ITER, DONE}
  - MICRO_ROT_CW=1'b0, MICRO_ROT_CCW=1'b1
  - function for counter width, $clog2(NUM_ITER)
- Sub-module vec_cordic_iter_dp: combinational shift-add datapath taking x, y and i, producing next x, next y and bit. The controller owns the registers and FSM.

Test Plan:
- Reset and idle: assert reset 3 cycles mid-ITER, then idle → all outputs 0, in_ready=1, no out_valid.
- Single vector x=1000, y=0, NUM_ITER=16, out_ready=1:
  - Strobes on cycles T+1..T+16; micro_rot_start only at T+1.
  - micro_rot_vec[3:0]=4'b1110.
  - Intermediate after i=3: x=1641, y=78.
  - Final x_out within 1647±16, |y_out|<=4.
  - out_valid at T+16.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs stable, in_ready=0 and a presented vector is not captured; release → accepted in 1 cycle.
- Back-to-back: in_valid held with vectors (1000,0) then (0,-500), out_ready=1 → second vector loads the cycle the first result fires; second out_valid exactly 16 cycles later; result for (0,-500) shows micro_rot_vec[1]=1.
- Abort: pulse abort at iteration 5 → IDLE next cycle, no out_valid, no further strobes; next vector (300,300) completes normally with y_out≈0.
- Negative-x and wrap: x=-2000, y=1 → bit pattern matches a bit-accurate reference model; separately x=y=2^(CORDIC_WIDTH-2) shows the documented wrap result (no saturation).
